// File: rtl/trigger_gate_ctrl_if.sv
// Control/status bundle between software-facing registers and trigger_gate_ctrl.
// Signal names follow the register map, so they carry no direction suffix.
interface trigger_gate_ctrl_if #(
    parameter int CNT_W = 32,
    parameter int REP_W = 16
);
    logic             go;
    logic             stop;
    logic             ext_trig;
    logic             start;
    logic             busy;
    logic             done;
    logic [REP_W-1:0] win_cnt;
    logic             MODE_REG;
    logic [CNT_W-1:0] DELAY_REG;
    logic [CNT_W-1:0] LENGTH_REG;
    logic [CNT_W-1:0] GAP_REG;
    logic [REP_W-1:0] REPEAT_REG;

    modport master (
        output go, stop, ext_trig,
        output MODE_REG, DELAY_REG, LENGTH_REG, GAP_REG, REPEAT_REG,
        input  start, busy, done, win_cnt
    );

    modport slave (
        input  go, stop, ext_trig,
        input  MODE_REG, DELAY_REG, LENGTH_REG, GAP_REG, REPEAT_REG,
        output start, busy, done, win_cnt
    );
endinterface

// File: rtl/trigger_gate_ctrl.sv
// Gating controller: delay, then REPEAT_REG+1 start windows separated by gaps.
// Define TRIG_GATE_EXT_SYNC_EN to put ext_trig through a 2-flop synchronizer.
module trigger_gate_ctrl #(
    parameter int CNT_W = 32,
    parameter int REP_W = 16
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    trigger_gate_ctrl_if.slave   gate_if
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TRIG = 3'd1,
        ST_DELAY     = 3'd2,
        ST_ACTIVE    = 3'd3,
        ST_GAP       = 3'd4,
        ST_DONE      = 3'd5
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [REP_W-1:0] REP_ONE = REP_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic [REP_W-1:0] win_cnt_q, win_cnt_d;
    logic             mode_q;
    logic [CNT_W-1:0] delay_q, length_q, gap_q;
    logic [REP_W-1:0] repeat_q;
    logic             start_q, busy_q, done_q;
    logic             trig_edge_s;
    logic             abort_s;

`ifdef TRIG_GATE_EXT_SYNC_EN
    logic sync1_q, sync2_q, sync2_dly_q, edge_q;

    // Synchronizer plus registered edge detector; two consecutive highs are needed.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync2_dly_q <= 1'b0;
            edge_q      <= 1'b0;
        end else begin
            sync1_q     <= gate_if.ext_trig;
            sync2_q     <= sync1_q;
            sync2_dly_q <= sync2_q;
            edge_q      <= sync1_q & sync2_q & ~sync2_dly_q;
        end
    end

    assign trig_edge_s = edge_q;
`else
    logic ext_dly_q;

    // Previous-cycle copy of the already-synchronous ext_trig.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            ext_dly_q <= 1'b0;
        end else begin
            ext_dly_q <= gate_if.ext_trig;
        end
    end

    assign trig_edge_s = gate_if.ext_trig & ~ext_dly_q;
`endif

    // Shadow copies track the registers only while idle, so a run uses frozen values.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            mode_q   <= 1'b0;
            delay_q  <= '0;
            length_q <= '0;
            gap_q    <= '0;
            repeat_q <= '0;
        end else if (state_q == ST_IDLE) begin
            mode_q   <= gate_if.MODE_REG;
            delay_q  <= gate_if.DELAY_REG;
            length_q <= gate_if.LENGTH_REG;
            gap_q    <= gate_if.GAP_REG;
            repeat_q <= gate_if.REPEAT_REG;
        end
    end

    // DONE is allowed to finish even under stop so the completion pulse is never lost.
    assign abort_s = gate_if.stop && (state_q != ST_IDLE) && (state_q != ST_DONE);

    // Next-state and counter logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rep_cnt_d = rep_cnt_q;
        win_cnt_d = win_cnt_q;
        if (abort_s) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            rep_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d     = '0;
                    rep_cnt_d = '0;
                    if (gate_if.go && !gate_if.stop) begin
                        win_cnt_d = '0;
                        state_d   = mode_q ? ST_WAIT_TRIG : ST_DELAY;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_edge_s) begin
                        state_d = ST_DELAY;
                    end else begin
                        state_d = ST_WAIT_TRIG;
                    end
                end
                ST_DELAY: begin
                    if (cnt_q == delay_q) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_ACTIVE: begin
                    if (cnt_q == length_q) begin
                        cnt_d     = '0;
                        win_cnt_d = win_cnt_q + REP_ONE;
                        if (rep_cnt_q == repeat_q) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d   = ST_GAP;
                            rep_cnt_d = rep_cnt_q + REP_ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt_q == gap_q) begin
                        state_d = ST_ACTIVE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    rep_cnt_d = '0;
                end
            endcase
        end
    end

    // State, counters and outputs; outputs are flops that mirror the next state.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rep_cnt_q <= '0;
            win_cnt_q <= '0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rep_cnt_q <= rep_cnt_d;
            win_cnt_q <= win_cnt_d;
            start_q   <= (state_d == ST_ACTIVE);
            busy_q    <= (state_d != ST_IDLE);
            done_q    <= (state_d == ST_DONE);
        end
    end

    assign gate_if.start   = start_q;
    assign gate_if.busy    = busy_q;
    assign gate_if.done    = done_q;
    assign gate_if.win_cnt = win_cnt_q;

endmodule

// File: tb/tb_trigger_gate_ctrl.sv
// Bench for trigger_gate_ctrl: directed scenarios plus random traffic checked
// every cycle against a timeline model built from the register values at launch.
module tb_trigger_gate_ctrl;
    localparam int CNT_W = 32;
    localparam int REP_W = 16;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    trigger_gate_ctrl_if #(.CNT_W(CNT_W), .REP_W(REP_W)) gif();

    trigger_gate_ctrl #(.CNT_W(CNT_W), .REP_W(REP_W)) dut (
        .aclk    (aclk),
        .aresetn (aresetn),
        .gate_if (gif)
    );

    int checks_n   = 0;
    int failures_n = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_n++;
        if (act !== exp) begin
            failures_n++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model: per-cycle expected timeline ----------------
    typedef struct packed {
        logic             s;
        logic             d;
        logic [REP_W-1:0] w;
    } step_t;

    step_t            plan[$];
    logic             e_start = 1'b0, e_busy = 1'b0, e_done = 1'b0;
    logic [REP_W-1:0] e_win = '0;
    logic             armed = 1'b0, prev_ext = 1'b0, model_on = 1'b0;
    logic             sh_mode = 1'b0, launch_mode;
    int unsigned      sh_d = 0, sh_l = 0, sh_g = 0, sh_r = 0;
    int               cyc = 0;

    task automatic build_plan();
        logic [REP_W-1:0] w;
        w = '0;
        plan.delete();
        for (int i = 0; i <= int'(sh_d); i++) plan.push_back('{1'b0, 1'b0, w});
        for (int k = 0; k <= int'(sh_r); k++) begin
            for (int i = 0; i <= int'(sh_l); i++) plan.push_back('{1'b1, 1'b0, w});
            w = w + 16'd1;
            if (k < int'(sh_r))
                for (int i = 0; i <= int'(sh_g); i++) plan.push_back('{1'b0, 1'b0, w});
        end
        plan.push_back('{1'b0, 1'b1, w});
    endtask

    task automatic advance();
        step_t st;
        if (plan.size() > 0) begin
            st      = plan.pop_front();
            e_start = st.s;
            e_done  = st.d;
            e_win   = st.w;
            e_busy  = 1'b1;
        end else begin
            e_start = 1'b0;
            e_done  = 1'b0;
            e_busy  = 1'b0;
        end
    endtask

    always @(posedge aclk) begin
        cyc++;
        model_on = 1'b1;
        if (!aresetn) begin
            plan.delete();
            armed = 1'b0; prev_ext = 1'b0;
            e_start = 1'b0; e_busy = 1'b0; e_done = 1'b0; e_win = '0;
            sh_mode = 1'b0; sh_d = 0; sh_l = 0; sh_g = 0; sh_r = 0;
        end else begin
            if (!e_busy) begin
                launch_mode = sh_mode;
                sh_mode = gif.MODE_REG;
                sh_d = gif.DELAY_REG; sh_l = gif.LENGTH_REG;
                sh_g = gif.GAP_REG;   sh_r = gif.REPEAT_REG;
                if (gif.go && !gif.stop) begin
                    e_win = '0;
                    if (launch_mode) begin
                        armed = 1'b1; e_busy = 1'b1; e_start = 1'b0; e_done = 1'b0;
                    end else begin
                        build_plan();
                        advance();
                    end
                end
            end else if (gif.stop && !e_done) begin
                plan.delete();
                armed = 1'b0; e_busy = 1'b0; e_start = 1'b0;
            end else if (armed) begin
                if (gif.ext_trig && !prev_ext) begin
                    armed = 1'b0;
                    build_plan();
                    advance();
                end
            end else begin
                advance();
            end
            prev_ext = gif.ext_trig;
        end
    end

    // ---------------- per-cycle comparison and run statistics ----------------
    int start_cnt = 0, first_start = -1, done_cnt = 0, done_cyc = -1;

    always @(negedge aclk) begin
        if (model_on) begin
            check_val("start",   {31'd0, gif.start}, {31'd0, e_start});
            check_val("busy",    {31'd0, gif.busy},  {31'd0, e_busy});
            check_val("done",    {31'd0, gif.done},  {31'd0, e_done});
            check_val("win_cnt", {16'd0, gif.win_cnt}, {16'd0, e_win});
        end
        if (gif.start === 1'b1) begin
            start_cnt++;
            if (first_start < 0) first_start = cyc;
        end
        if (gif.done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_mon();
        start_cnt = 0; first_start = -1; done_cnt = 0; done_cyc = -1;
    endtask

    task automatic set_cfg(input logic m, input int d, input int l, input int g, input int r);
        gif.MODE_REG   = m;
        gif.DELAY_REG  = CNT_W'(d);
        gif.LENGTH_REG = CNT_W'(l);
        gif.GAP_REG    = CNT_W'(g);
        gif.REPEAT_REG = REP_W'(r);
    endtask

    task automatic pulse_go();
        gif.go = 1'b1;
        tick();
        gif.go = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && gif.busy !== 1'b0; i++) tick();
        check_val("idle_timeout", {31'd0, gif.busy}, 32'd0);
    endtask

    int g0, e0;

    initial begin
        gif.go = 1'b0; gif.stop = 1'b0; gif.ext_trig = 1'b0;
        set_cfg(1'b0, 0, 0, 0, 0);
        repeat (3) tick();
        check_val("rst_busy",  {31'd0, gif.busy},  32'd0);
        check_val("rst_start", {31'd0, gif.start}, 32'd0);
        check_val("rst_win",   {16'd0, gif.win_cnt}, 32'd0);
        aresetn = 1'b1;
        tick();

        // Basic three-window run.
        set_cfg(1'b0, 0, 3, 1, 2); repeat (3) tick(); clear_mon();
        g0 = cyc; pulse_go(); wait_idle(100);
        check_val("t1_first_start", 32'(first_start - g0), 32'd2);
        check_val("t1_start_cycles", 32'(start_cnt), 32'd12);
        check_val("t1_done_at", 32'(done_cyc - g0), 32'd18);
        check_val("t1_win", {16'd0, gif.win_cnt}, 32'd3);

        // Externally triggered single-cycle window.
        set_cfg(1'b1, 4, 0, 0, 0); repeat (3) tick(); clear_mon();
        pulse_go(); repeat (5) tick();
        check_val("t2_armed_busy", {31'd0, gif.busy}, 32'd1);
        gif.ext_trig = 1'b1; e0 = cyc; repeat (4) tick(); gif.ext_trig = 1'b0;
        wait_idle(50);
        check_val("t2_first_start", 32'(first_start - e0), 32'd6);
        check_val("t2_done_at", 32'(done_cyc - e0), 32'd7);
        check_val("t2_start_cycles", 32'(start_cnt), 32'd1);

        // Abort in the 20th active cycle, then relaunch.
        set_cfg(1'b0, 0, 100, 0, 0); repeat (3) tick(); clear_mon();
        pulse_go(); repeat (20) tick();
        gif.stop = 1'b1; tick(); gif.stop = 1'b0;
        check_val("t3_start_off", {31'd0, gif.start}, 32'd0);
        check_val("t3_busy_off", {31'd0, gif.busy}, 32'd0);
        check_val("t3_win", {16'd0, gif.win_cnt}, 32'd0);
        repeat (3) tick();
        check_val("t3_no_done", 32'(done_cnt), 32'd0);
        set_cfg(1'b0, 0, 2, 0, 0); repeat (2) tick(); clear_mon();
        pulse_go(); wait_idle(50);
        check_val("t3_relaunch_start", 32'(start_cnt), 32'd3);
        check_val("t3_relaunch_done", 32'(done_cnt), 32'd1);

        // go+stop together in idle; go during ACTIVE is ignored.
        gif.go = 1'b1; gif.stop = 1'b1; tick(); gif.go = 1'b0; gif.stop = 1'b0;
        check_val("t4_stays_idle", {31'd0, gif.busy}, 32'd0);
        set_cfg(1'b0, 1, 5, 1, 1); repeat (2) tick(); clear_mon();
        pulse_go(); repeat (5) tick();
        check_val("t4_in_active", {31'd0, gif.start}, 32'd1);
        pulse_go(); wait_idle(100);
        check_val("t4_win", {16'd0, gif.win_cnt}, 32'd2);
        check_val("t4_start_cycles", 32'(start_cnt), 32'd12);
        check_val("t4_done_cnt", 32'(done_cnt), 32'd1);

        // Register change mid-run only affects the next run.
        set_cfg(1'b0, 0, 3, 1, 1); repeat (2) tick(); clear_mon();
        pulse_go(); tick(); gif.LENGTH_REG = 32'd7; wait_idle(100);
        check_val("t5_run1_start", 32'(start_cnt), 32'd8);
        tick(); clear_mon(); pulse_go(); wait_idle(100);
        check_val("t5_run2_start", 32'(start_cnt), 32'd16);

        // Reset during GAP.
        set_cfg(1'b0, 0, 3, 2, 2); repeat (2) tick();
        pulse_go(); repeat (6) tick();
        check_val("t6_in_gap", {31'd0, gif.start}, 32'd0);
        check_val("t6_busy_gap", {31'd0, gif.busy}, 32'd1);
        aresetn = 1'b0; tick();
        check_val("t6_rst_start", {31'd0, gif.start}, 32'd0);
        check_val("t6_rst_busy", {31'd0, gif.busy}, 32'd0);
        check_val("t6_rst_win", {16'd0, gif.win_cnt}, 32'd0);
        aresetn = 1'b1; tick();

        // Random traffic; the model checks every cycle.
        for (int n = 0; n < 4000; n++) begin
            gif.go   = ($urandom_range(0, 9) == 0);
            gif.stop = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 4) == 0) gif.ext_trig = ~gif.ext_trig;
            if ($urandom_range(0, 24) == 0)
                set_cfg(1'($urandom_range(0, 1)), $urandom_range(0, 4), $urandom_range(0, 4),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            aresetn = ($urandom_range(0, 699) != 0);
            tick();
        end
        gif.go = 1'b0; gif.stop = 1'b0; gif.ext_trig = 1'b0; aresetn = 1'b1;
        repeat (5) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks_n, failures_n);
        $finish;
    end
endmodule
